// File: rtl/booth_pp_gen_pkg.sv
// Shared FPU mantissa-multiplier constants and the radix-4 Booth digit encoding.
// Imported by booth_pp_gen and booth_digit_enc.
package booth_pp_gen_pkg;

  localparam int C_MANT = 23;
  localparam int C_OPW  = C_MANT + 1;
  localparam int C_NPP  = (C_MANT + 3) / 2;
  localparam int C_PPW  = 2 * C_MANT + 3;
  localparam int C_BEXT = C_OPW + 3;
  localparam int C_PPV  = C_NPP * C_PPW;

  // One Booth digit in {-2..+2}: magnitude select (one/two) plus sign.
  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth recoder: one overlapping multiplier bit triple to {neg, one, two}.
// Purely combinational; 3'b111 maps to a positive zero so no negative-zero PP exists.
module booth_digit_enc
  import booth_pp_gen_pkg::*;
(
  input  logic [2:0]   triple,
  output booth_digit_t digit
);

  always_comb begin
    digit = '0;
    unique case (triple)
      3'b001, 3'b010: digit.one = 1'b1;
      3'b011: digit.two = 1'b1;
      3'b100: begin
        digit.neg = 1'b1;
        digit.two = 1'b1;
      end
      3'b101, 3'b110: begin
        digit.neg = 1'b1;
        digit.one = 1'b1;
      end
      default: digit = '0;
    endcase
  end

endmodule

// File: rtl/booth_pp_gen.sv
// Two-stage radix-4 Booth partial-product generator (recode, then PP form) feeding the Wallace tree.
// Optional FPU_PP_OPERAND_GATE_EN: load data only on valid transfers and zero the PP bus when idle.
module booth_pp_gen
  import booth_pp_gen_pkg::*;
(
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             Flush_SI,
  input  logic             Valid_SI,
  output logic             Ready_SO,
  input  logic [C_OPW-1:0] Mant_a_DI,
  input  logic [C_OPW-1:0] Mant_b_DI,
  output logic             Valid_SO,
  input  logic             Ready_SI,
  output logic [C_PPV-1:0] Pp_index_DO
);

  localparam logic [C_PPW-1:0] PP_ONE = {{(C_PPW-1){1'b0}}, 1'b1};

  logic                     s1_valid, s2_valid;
  logic                     s1_adv, s2_adv;
  logic                     s1_load, s2_load;
  logic [C_BEXT-1:0]        b_ext;
  booth_digit_t [C_NPP-1:0] dig_d;
  booth_digit_t [C_NPP-1:0] s1_dig;
  logic [C_OPW-1:0]         s1_a;
  logic [C_PPV-1:0]         pp_d;
  logic [C_PPV-1:0]         s2_pp;
  logic [C_PPW-1:0]         mag;
  logic [C_PPW-1:0]         pp_val;

  assign s2_adv   = ~s2_valid | Ready_SI;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign Ready_SO = s1_adv;
  assign Valid_SO = s2_valid;

`ifdef FPU_PP_OPERAND_GATE_EN
  assign s1_load     = s1_adv & Valid_SI;
  assign s2_load     = s2_adv & s1_valid;
  assign Pp_index_DO = s2_valid ? s2_pp : '0;
`else
  assign s1_load     = s1_adv;
  assign s2_load     = s2_adv;
  assign Pp_index_DO = s2_pp;
`endif

  // Stage 1: recode B; the top triple only ever sees {0,0,B[msb]}.
  assign b_ext = {2'b00, Mant_b_DI, 1'b0};

  for (genvar i = 0; i < C_NPP; i++) begin : gen_enc
    booth_digit_enc u_enc (
      .triple (b_ext[2*i+2 -: 3]),
      .digit  (dig_d[i])
    );
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (Flush_SI) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s2_adv) s2_valid <= s1_valid;
      if (s1_adv) s1_valid <= Valid_SI;
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      s1_a   <= '0;
      s1_dig <= '0;
      s2_pp  <= '0;
    end else begin
      if (s1_load) begin
        s1_a   <= Mant_a_DI;
        s1_dig <= dig_d;
      end
      if (s2_load) s2_pp <= pp_d;
    end
  end

  // Stage 2: select 0/A/2A, negate in full two's complement (the +1 folded in), shift by 2i.
  always_comb begin
    pp_d   = '0;
    mag    = '0;
    pp_val = '0;
    for (int i = 0; i < C_NPP; i++) begin
      if (s1_dig[i].two)
        mag = {{(C_PPW-C_OPW-1){1'b0}}, s1_a, 1'b0};
      else if (s1_dig[i].one)
        mag = {{(C_PPW-C_OPW){1'b0}}, s1_a};
      else
        mag = '0;
      pp_val = s1_dig[i].neg ? (~mag + PP_ONE) : mag;
      pp_d[i*C_PPW +: C_PPW] = pp_val << (2*i);
    end
  end

endmodule
